// File: rtl/fwft_if.sv
// FWFT width-converting FIFO handshake bundle.
// Write side takes full words, read side delivers halfwords.
interface fwft_if #(
  parameter int DATA_WIDTH = 16
);
  localparam int OUT_WIDTH = DATA_WIDTH / 2;

  logic                  wr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  rd;
  logic [OUT_WIDTH-1:0]  rd_data;
  logic                  empty;

  modport master (
    output wr,
    output wr_data,
    output rd,
    input  full,
    input  rd_data,
    input  empty
  );

  modport slave (
    input  wr,
    input  wr_data,
    input  rd,
    output full,
    output rd_data,
    output empty
  );
endinterface

// File: rtl/fwft.sv
// First-word-fall-through FIFO, word in / halfword out.
// Low half of each word is read first, then the high half.
module fwft #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
) (
  input  logic   clk,
  input  logic   arst_n,
  fwft_if.slave  bus
);
  localparam int OUT_WIDTH = DATA_WIDTH / 2;
  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_FULL =
    (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic                  r_half;
  logic [ADDR_WIDTH:0]   r_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_word;
  logic [OUT_WIDTH-1:0]  w_rd_data;

  assign w_full   = (r_count == LP_FULL);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = bus.wr & ~w_full & ~arst_n;
  assign w_rd_acc = bus.rd & ~w_empty;
  assign w_pop    = w_rd_acc & r_half;
  assign w_word   = r_mem[r_rptr];

  // Store accepted words; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= bus.wr_data;
    end
  end

  // Pointers, half-select and word occupancy.
  always_ff @(posedge clk) begin
    if (arst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_half  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_half <= ~r_half;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_wr_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Present the selected half of the head word, zero when empty.
  always_comb begin
    w_rd_data = '0;
    if (!w_empty) begin
      if (r_half) begin
        w_rd_data = w_word[DATA_WIDTH-1:OUT_WIDTH];
      end else begin
        w_rd_data = w_word[OUT_WIDTH-1:0];
      end
    end
  end

  assign bus.full    = w_full;
  assign bus.empty   = w_empty;
  assign bus.rd_data = w_rd_data;
endmodule

// File: tb/tb_fwft.sv
// Bench for fwft: directed scenarios plus random traffic,
// checked against a halfword-queue reference model.
module tb_fwft;
  localparam int DW = 16;
  localparam int OW = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic arst_n;

  fwft_if #(.DATA_WIDTH(DW)) bus ();

  fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(2)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [OW-1:0] hq[$];

  function automatic logic m_empty();
    return hq.size() == 0;
  endfunction

  function automatic logic m_full();
    return ((hq.size() + 1) / 2) == DEPTH;
  endfunction

  function automatic logic [OW-1:0] m_data();
    if (hq.size() == 0) return '0;
    return hq[0];
  endfunction

  task automatic chk(input string tag);
    vecs++;
    assert (bus.empty === m_empty()) else begin
      errs++;
      $error("FAIL %s.empty got %b exp %b",
             tag, bus.empty, m_empty());
    end
    vecs++;
    assert (bus.full === m_full()) else begin
      errs++;
      $error("FAIL %s.full got %b exp %b",
             tag, bus.full, m_full());
    end
    vecs++;
    assert (bus.rd_data === m_data()) else begin
      errs++;
      $error("FAIL %s.rd_data got %h exp %h",
             tag, bus.rd_data, m_data());
    end
  endtask

  task automatic chk_const(input string tag,
                           input logic [OW-1:0] d,
                           input logic e,
                           input logic f);
    vecs++;
    assert (bus.rd_data === d && bus.empty === e &&
            bus.full === f) else begin
      errs++;
      $error("FAIL %s got d=%h e=%b f=%b exp d=%h e=%b f=%b",
             tag, bus.rd_data, bus.empty, bus.full, d, e, f);
    end
  endtask

  // Drive one cycle from a negedge, update model, check at next negedge.
  task automatic step(input string tag, input logic w,
                      input logic r, input logic [DW-1:0] d,
                      input logic rst);
    logic acc_w;
    logic acc_r;
    bus.wr      = w;
    bus.rd      = r;
    bus.wr_data = d;
    arst_n      = rst;
    acc_w = w && !m_full();
    acc_r = r && !m_empty();
    @(posedge clk);
    if (rst) begin
      hq.delete();
    end else begin
      if (acc_r) void'(hq.pop_front());
      if (acc_w) begin
        hq.push_back(d[OW-1:0]);
        hq.push_back(d[DW-1:OW]);
      end
    end
    @(negedge clk);
    chk(tag);
  endtask

  initial begin
    logic [DW-1:0] wd;
    bus.wr = 0; bus.rd = 0; bus.wr_data = '0; arst_n = 1;
    @(negedge clk);

    step("rst0", 0, 0, 0, 1);
    step("rst1", 1, 1, 16'hFFFF, 1);
    chk_const("rst_state", 8'h00, 1, 0);

    step("r27w", 1, 0, 16'h1234, 0);
    chk_const("r27_lo", 8'h34, 0, 0);
    step("r27r1", 0, 1, 0, 0);
    chk_const("r27_hi", 8'h12, 0, 0);
    step("r27r2", 0, 1, 0, 0);
    chk_const("r27_empty", 8'h00, 1, 0);

    step("r28w1", 1, 0, 16'h1111, 0);
    step("r28w2", 1, 0, 16'h2222, 0);
    step("r28w3", 1, 0, 16'h3333, 0);
    step("r28w4", 1, 0, 16'h4444, 0);
    chk_const("r28_full", 8'h11, 0, 1);
    step("r28w5", 1, 0, 16'h5555, 0);
    for (int i = 0; i < 8; i++) step("r28rd", 0, 1, 0, 0);
    chk_const("r28_empty", 8'h00, 1, 0);

    for (int i = 0; i < 4; i++) step("r29w", 1, 0, 16'hA0B0 + 16'(i), 0);
    step("r29lo", 0, 1, 0, 0);
    chk_const("r29_half", 8'hA0, 0, 1);
    step("r29wrfull", 1, 1, 16'hDEAD, 0);
    chk_const("r29_freed", 8'hB1, 0, 0);
    step("r29w", 1, 0, 16'hC0C1, 0);
    chk_const("r29_refull", 8'hB1, 0, 1);
    for (int i = 0; i < 10; i++) step("r29drain", 0, 1, 0, 0);

    for (int i = 0; i < 10; i++) step("r30w", 1, 0, 16'($urandom), 0);
    for (int i = 0; i < 10; i++) step("r30r", 0, 1, 0, 0);
    chk_const("r30_empty", 8'h00, 1, 0);

    for (int i = 0; i < 30; i++) begin
      wd = 16'($urandom);
      step("r31", (i % 2) == 0, 1, wd, 0);
    end
    for (int i = 0; i < 4; i++) step("r31tail", 0, 1, 0, 0);

    for (int i = 0; i < 3; i++) step("r32w", 1, 0, 16'h0101 * 16'(i + 1), 0);
    step("r32r", 0, 1, 0, 0);
    step("r32rst", 1, 1, 16'h7777, 1);
    chk_const("r32_rst", 8'h00, 1, 0);
    step("r32w", 1, 0, 16'hABCD, 0);
    chk_const("r32_lo", 8'hCD, 0, 0);
    step("r32r1", 0, 1, 0, 0);
    chk_const("r32_hi", 8'hAB, 0, 0);
    step("r32r2", 0, 1, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 16'($urandom),
           $urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
